// File: rtl/serial_paralelo_pkg.sv
// serial_paralelo_pkg: shared states, symbol constants and counter width for the lane deserializer
package serial_paralelo_pkg;
  typedef enum logic [1:0] {SEARCH, SYNC, ACTIVE} sp_state_t;
  localparam logic [7:0] SP_COM = 8'hBC;
  localparam logic [7:0] SP_IDLE = 8'h7C;
  localparam int SP_CNT_W = 4;
endpackage

// File: rtl/sp_comma_match.sv
// sp_comma_match: combinational COM / IDLE recogniser on the current bit window
module sp_comma_match #(
  parameter int DATA_W = 8,
  parameter logic [DATA_W-1:0] COM = 8'hBC,
  parameter logic [DATA_W-1:0] IDLE = 8'h7C
) (
  input  logic [DATA_W-1:0] win,
  output logic              is_com,
  output logic              is_idle
);
  assign is_com = win == COM;
  assign is_idle = win == IDLE;
endmodule

// File: rtl/serial_paralelo.sv
// serial_paralelo: COM-aligned serial-to-byte deserializer; define SP_IDLE_FILTER_EN to drop IDLE bytes once locked
module serial_paralelo
  import serial_paralelo_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter logic [DATA_W-1:0] COM = SP_COM,
  parameter logic [DATA_W-1:0] IDLE = SP_IDLE,
  parameter int LOCK_COUNT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enb,
  input  logic              serial_in,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              active,
  output logic              com_det
);
`ifdef SP_IDLE_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif
  localparam logic [SP_CNT_W-1:0] LC = SP_CNT_W'(LOCK_COUNT);
  sp_state_t state;
  logic [DATA_W-1:0] shreg, win;
  logic [2:0] bcnt;
  logic [SP_CNT_W-1:0] ccnt, ccnt_inc;
  logic is_com, is_idle, boundary;
  assign win = {shreg[DATA_W-2:0], serial_in};
  assign boundary = bcnt == 3'd7;
  assign ccnt_inc = (ccnt == LC) ? ccnt : ccnt + 1'b1;
  assign active = state == ACTIVE;
  sp_comma_match #(.DATA_W(DATA_W), .COM(COM), .IDLE(IDLE)) u_match (
    .win(win), .is_com(is_com), .is_idle(is_idle)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SEARCH;
      shreg <= '0;
      bcnt <= '0;
      ccnt <= '0;
      data_out <= '0;
      valid_out <= 1'b0;
      com_det <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      com_det <= 1'b0;
      if (!enb) begin
        // a gap in the bit stream loses alignment: restart the search
        if (state != SEARCH) begin
          state <= SEARCH;
          ccnt <= '0;
          bcnt <= '0;
        end
      end else begin
        shreg <= win;
        bcnt <= bcnt + 3'd1;
        case (state)
          SEARCH: if (is_com) begin
            state <= SYNC;
            bcnt <= '0;
            ccnt <= SP_CNT_W'(1);
            com_det <= 1'b1;
          end
          SYNC: if (boundary) begin
            if (is_com) begin
              ccnt <= ccnt_inc;
              com_det <= 1'b1;
              if (ccnt + 1'b1 == LC) state <= ACTIVE;
            end else begin
              state <= SEARCH;
              ccnt <= '0;
            end
          end
          ACTIVE: if (boundary) begin
            com_det <= is_com;
            if (!(FILT && is_idle)) begin
              data_out <= win;
              valid_out <= 1'b1;
            end
          end
          default: state <= SEARCH;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_serial_paralelo.sv
// tb_serial_paralelo: randomized scoreboard bench for serial_paralelo against a bit-stream reference model
module tb_serial_paralelo;
  localparam int LC = 4;
`ifdef SP_IDLE_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif
  typedef struct {int stamp; logic [7:0] d;} ev_t;
  typedef struct {int stamp; logic act; logic [7:0] d;} cy_t;
  logic clk = 0, rst = 1, enb = 0, serial_in = 0;
  logic [7:0] data_out;
  logic valid_out, active, com_det;
  int cyc = 0, checks = 0, passes = 0;
  ev_t dq[$];
  int cq[$];
  cy_t yq[$];
  int m_mode = 0, m_n = 0, m_pos = 0;
  logic [7:0] m_hist = 0, m_dout = 0;

  serial_paralelo #(.LOCK_COUNT(LC)) dut (
    .clk(clk), .rst(rst), .enb(enb), .serial_in(serial_in),
    .data_out(data_out), .valid_out(valid_out), .active(active), .com_det(com_det)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [7:0] got, logic [7:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, got, exp);
  endfunction

  // reference: counts bits since the anchoring COM and acts on every eighth
  task automatic model(input logic r, input logic e, input logic b);
    if (r) begin
      m_mode = 0; m_n = 0; m_pos = 0; m_hist = 0; m_dout = 0;
    end else if (!e) begin
      if (m_mode != 0) begin m_mode = 0; m_n = 0; end
    end else begin
      m_hist = {m_hist[6:0], b};
      if (m_mode == 0) begin
        if (m_hist == 8'hBC) begin
          m_mode = 1; m_n = 1; m_pos = 0; cq.push_back(cyc + 1);
        end
      end else begin
        m_pos++;
        if (m_pos == 8) begin
          m_pos = 0;
          if (m_mode == 1) begin
            if (m_hist == 8'hBC) begin
              m_n++;
              cq.push_back(cyc + 1);
              if (m_n == LC) m_mode = 2;
            end else begin
              m_mode = 0; m_n = 0;
            end
          end else begin
            if (m_hist == 8'hBC) cq.push_back(cyc + 1);
            if (!(FILT && m_hist == 8'h7C)) begin
              m_dout = m_hist;
              dq.push_back('{cyc + 1, m_hist});
            end
          end
        end
      end
    end
    yq.push_back('{cyc + 1, m_mode == 2, m_dout});
  endtask

  task automatic step(input logic r, input logic e, input logic b);
    @(negedge clk);
    rst = r; enb = e; serial_in = b;
    model(r, e, b);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) step(0, 1, v[i]);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      step(1, 1, 1'($urandom));
      @(posedge clk); #1;
      chk("rst_valid", {7'd0, valid_out}, 8'd0);
      chk("rst_com", {7'd0, com_det}, 8'd0);
      chk("rst_active", {7'd0, active}, 8'd0);
      chk("rst_data", data_out, 8'd0);
    end
  endtask

  always @(negedge clk) begin
    while (yq.size() > 0 && yq[0].stamp < cyc) void'(yq.pop_front());
    if (yq.size() > 0 && yq[0].stamp == cyc) begin
      chk("active", {7'd0, active}, {7'd0, yq[0].act});
      chk("data_out", data_out, yq[0].d);
      void'(yq.pop_front());
    end
    while (dq.size() > 0 && dq[0].stamp < cyc) begin
      chk("valid_missed", 8'd0, 8'd1);
      void'(dq.pop_front());
    end
    if (valid_out) begin
      if (dq.size() > 0 && dq[0].stamp == cyc) begin
        chk("byte", data_out, dq[0].d);
        void'(dq.pop_front());
      end else chk("valid_unexpected", 8'd1, 8'd0);
    end
    while (cq.size() > 0 && cq[0] < cyc) begin
      chk("com_missed", 8'd0, 8'd1);
      void'(cq.pop_front());
    end
    if (com_det) begin
      if (cq.size() > 0 && cq[0] == cyc) begin
        chk("com_det", 8'd1, 8'd1);
        void'(cq.pop_front());
      end else chk("com_unexpected", 8'd1, 8'd0);
    end
  end

  initial begin
    do_reset(4);
    repeat (LC) send_byte(8'hBC);
    send_byte(8'h55);
    send_byte(8'hA3);
    do_reset(1);
    repeat (3) step(0, 1, 1'($urandom));
    repeat (3) send_byte(8'hBC);
    send_byte(8'h00);
    repeat (LC) send_byte(8'hBC);
    send_byte(8'h3C);
    step(0, 0, 1'b1);
    send_byte(8'h81);
    repeat (LC) send_byte(8'hBC);
    send_byte(8'h7C);
    send_byte(8'h12);
    repeat (3) step(0, 1, 1'($urandom));
    do_reset(2);
    send_byte(8'h5A);
    send_byte(8'hE7);
    for (int it = 0; it < 300; it++) begin
      int k, n;
      k = int'($urandom_range(0, 9));
      n = int'($urandom_range(1, 6));
      if (k < 4) repeat (n) send_byte(8'hBC);
      else if (k < 6) send_byte(8'($urandom));
      else if (k == 6) send_byte(8'h7C);
      else if (k == 7) repeat (n) step(0, 1, 1'($urandom));
      else if (k == 8) repeat ((n + 1) / 3) step(0, 0, 1'($urandom));
      else if ($urandom_range(0, 3) == 0) do_reset(1);
      else send_byte(8'h12);
    end
    step(1, 1, 1'b0);
    repeat (3) @(negedge clk);
    chk("byte_queue_drained", 8'(dq.size()), 8'd0);
    chk("com_queue_drained", 8'(cq.size()), 8'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
